// File: rtl/usb_transmitter_pkg.sv
// Shared definitions for the full-speed USB transmit path.
// Holds the transmitter state encoding, the line-state codes driven onto
// {D+, D-}, the SYNC pattern and the PID values used by the protocol layer.
package usb_transmitter_pkg;

  typedef enum logic [2:0] {
    STATE_IDLE,
    STATE_SYNC,
    STATE_DATA,
    STATE_EOP_SE0,
    STATE_EOP_J,
    STATE_ABORT
  } tx_state_t;

  // Line states as {D+, D-}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam logic [7:0] USB_SYNC_BYTE = 8'h80;

  typedef enum logic [7:0] {
    PID_ACK   = 8'hD2,
    PID_NAK   = 8'h5A,
    PID_DATA0 = 8'hC3,
    PID_DATA1 = 8'h4B
  } usb_pid_t;

  // States in which no new byte may be accepted
  function automatic logic is_eop_or_abort(input tx_state_t s);
    return (s == STATE_EOP_SE0) || (s == STATE_EOP_J) || (s == STATE_ABORT);
  endfunction

endpackage

// File: rtl/usb_transmitter_bit_encoder.sv
// NRZI line encoder with bit stuffing for the USB transmitter.
// On each bit_strobe it launches one line state:
//   - a stuffed toggle if STUFF_RUN ones have been sent with stuffing enabled
//     (stuff_inserted is raised so the sequencer holds its data bit),
//   - otherwise SE0 when force_se0 is set,
//   - otherwise the NRZI encoding of bit_value (0 toggles, 1 holds).
// Ports:
//   clock48, reset_n         clock / async active-low reset
//   bit_strobe               launch a new line state this cycle
//   bit_value                data bit to encode
//   stuff_enable             count ones and stuff; when low the run is cleared
//   force_se0                drive SE0 (level returns to J afterwards)
//   usb_d_p_out/usb_d_n_out  pad drive levels
//   stuff_inserted           this strobe was consumed by a stuff bit
module usb_tx_bit_encoder
  import usb_transmitter_pkg::*;
#(
  parameter int unsigned STUFF_RUN = 6
) (
  input  logic clock48,
  input  logic reset_n,
  input  logic bit_strobe,
  input  logic bit_value,
  input  logic stuff_enable,
  input  logic force_se0,
  output logic usb_d_p_out,
  output logic usb_d_n_out,
  output logic stuff_inserted
);

  localparam int unsigned CW = $clog2(STUFF_RUN + 1);

  logic [CW-1:0] ones_cnt;
  logic          level;     // 1 = J, 0 = K
  logic          se0;

  assign stuff_inserted = bit_strobe && stuff_enable && (ones_cnt == CW'(STUFF_RUN));

  always_ff @(posedge clock48 or negedge reset_n) begin
    if (!reset_n) begin
      ones_cnt <= '0;
      level    <= 1'b1;
      se0      <= 1'b0;
    end else if (bit_strobe) begin
      if (stuff_inserted) begin
        level    <= ~level;
        se0      <= 1'b0;
        ones_cnt <= '0;
      end else if (force_se0) begin
        // Level parks at J so the bit after SE0 can be sent as a plain hold
        level    <= 1'b1;
        se0      <= 1'b1;
        ones_cnt <= '0;
      end else begin
        se0 <= 1'b0;
        if (!bit_value) begin
          level    <= ~level;
          ones_cnt <= '0;
        end else if (stuff_enable) begin
          ones_cnt <= ones_cnt + 1'b1;
        end else begin
          ones_cnt <= '0;
        end
      end
    end
  end

  always_comb begin
    {usb_d_p_out, usb_d_n_out} = LINE_J;
    if (se0)
      {usb_d_p_out, usb_d_n_out} = LINE_SE0;
    else if (!level)
      {usb_d_p_out, usb_d_n_out} = LINE_K;
  end

endmodule

// File: rtl/usb_transmitter.sv
// Full-speed USB transmitter (12 Mb/s on a 48 MHz clock).
// Takes packet bytes over a valid/ready stream and sends SYNC, the NRZI
// bit-stuffed bytes (LSB first) and EOP. If the next byte is not available
// at a byte boundary of an unfinished packet, the packet is aborted with a
// run of unstuffed ones followed by EOP.
// Ports:
//   clock48, reset_n           clock / async active-low reset
//   tx_valid, tx_data, tx_last input byte stream (PID first)
//   tx_ready                   byte accepted when tx_valid && tx_ready
//   tx_busy                    high from first accept until usb_oe falls
//   tx_underrun                one-cycle pulse when an abort starts
//   usb_d_p_out, usb_d_n_out   pad drive levels
//   usb_oe                     pad output enable
module usb_transmitter
  import usb_transmitter_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT = 4,
  parameter int unsigned EOP_SE0_BITS   = 2,
  parameter int unsigned STUFF_RUN      = 6
) (
  input  logic       clock48,
  input  logic       reset_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_underrun,
  output logic       usb_d_p_out,
  output logic       usb_d_n_out,
  output logic       usb_oe
);

  localparam int unsigned PW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(CLOCKS_PER_BIT - 1);
  localparam logic [2:0]    EOP_LAST   = 3'(EOP_SE0_BITS - 1);

  tx_state_t     state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    hold_data_q, hold_data_d;
  logic          hold_last_q, hold_last_d;
  logic          hold_full_q, hold_full_d;
  logic          cur_last_q, cur_last_d;
  logic          last_acc_q, last_acc_d;
  logic          oe_q, oe_d;
  logic          underrun_q, underrun_d;
  logic          ready_q, ready_d;

  logic accept;
  logic wrap;
  logic enc_strobe;
  logic enc_bit;
  logic enc_stuff_en;
  logic enc_force_se0;
  logic stuff_ins;

  assign accept = tx_valid && ready_q;
  assign wrap   = (phase_q == PHASE_LAST);

  // The strobe and stuff enable depend only on registered state, so the
  // encoder's stall flag can steer the sequencer without a combinational loop.
  assign enc_strobe   = (state_q == STATE_IDLE) ? accept : wrap;
  assign enc_stuff_en = (state_q == STATE_DATA) ||
                        ((state_q == STATE_SYNC) && (bit_cnt_q == 3'd7));

  usb_tx_bit_encoder #(
    .STUFF_RUN(STUFF_RUN)
  ) u_encoder (
    .clock48        (clock48),
    .reset_n        (reset_n),
    .bit_strobe     (enc_strobe),
    .bit_value      (enc_bit),
    .stuff_enable   (enc_stuff_en),
    .force_se0      (enc_force_se0),
    .usb_d_p_out    (usb_d_p_out),
    .usb_d_n_out    (usb_d_n_out),
    .stuff_inserted (stuff_ins)
  );

  always_ff @(posedge clock48 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= STATE_IDLE;
      phase_q     <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      hold_data_q <= '0;
      hold_last_q <= 1'b0;
      hold_full_q <= 1'b0;
      cur_last_q  <= 1'b0;
      last_acc_q  <= 1'b0;
      oe_q        <= 1'b0;
      underrun_q  <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      hold_data_q <= hold_data_d;
      hold_last_q <= hold_last_d;
      hold_full_q <= hold_full_d;
      cur_last_q  <= cur_last_d;
      last_acc_q  <= last_acc_d;
      oe_q        <= oe_d;
      underrun_q  <= underrun_d;
      ready_q     <= ready_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    hold_data_d   = hold_data_q;
    hold_last_d   = hold_last_q;
    hold_full_d   = hold_full_q;
    cur_last_d    = cur_last_q;
    last_acc_d    = last_acc_q;
    oe_d          = oe_q;
    underrun_d    = 1'b0;
    enc_bit       = 1'b1;
    enc_force_se0 = 1'b0;

    if ((state_q == STATE_IDLE) || wrap)
      phase_d = '0;
    else
      phase_d = phase_q + 1'b1;

    if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = tx_data;
      hold_last_d = tx_last;
      if (tx_last)
        last_acc_d = 1'b1;
    end

    unique case (state_q)
      STATE_IDLE: begin
        if (accept) begin
          state_d   = STATE_SYNC;
          oe_d      = 1'b1;
          bit_cnt_d = '0;
          enc_bit   = USB_SYNC_BYTE[0];
        end
      end

      STATE_SYNC: begin
        if (wrap) begin
          if (bit_cnt_q != 3'd7) begin
            enc_bit   = USB_SYNC_BYTE[bit_cnt_q + 3'd1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else begin
            state_d     = STATE_DATA;
            shift_d     = hold_data_q;
            cur_last_d  = hold_last_q;
            hold_full_d = 1'b0;
            enc_bit     = hold_data_q[0];
            bit_cnt_d   = '0;
          end
        end
      end

      STATE_DATA: begin
        // A stuff bit takes this strobe; the data position is left untouched
        if (wrap && !stuff_ins) begin
          if (bit_cnt_q != 3'd7) begin
            shift_d   = {1'b0, shift_q[7:1]};
            enc_bit   = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else if (cur_last_q) begin
            state_d       = STATE_EOP_SE0;
            enc_force_se0 = 1'b1;
            bit_cnt_d     = '0;
          end else if (hold_full_q) begin
            shift_d     = hold_data_q;
            cur_last_d  = hold_last_q;
            hold_full_d = 1'b0;
            enc_bit     = hold_data_q[0];
            bit_cnt_d   = '0;
          end else if (accept) begin
            // Byte arriving exactly at the boundary goes straight to the shifter
            shift_d     = tx_data;
            cur_last_d  = tx_last;
            hold_full_d = 1'b0;
            enc_bit     = tx_data[0];
            bit_cnt_d   = '0;
          end else begin
            state_d    = STATE_ABORT;
            underrun_d = 1'b1;
            enc_bit    = 1'b1;
            bit_cnt_d  = '0;
          end
        end
      end

      STATE_EOP_SE0: begin
        if (wrap) begin
          if (bit_cnt_q != EOP_LAST) begin
            enc_force_se0 = 1'b1;
            bit_cnt_d     = bit_cnt_q + 3'd1;
          end else begin
            state_d   = STATE_EOP_J;
            enc_bit   = 1'b1;
            bit_cnt_d = '0;
          end
        end
      end

      STATE_EOP_J: begin
        if (wrap) begin
          state_d    = STATE_IDLE;
          oe_d       = 1'b0;
          last_acc_d = 1'b0;
        end
      end

      STATE_ABORT: begin
        if (wrap) begin
          if (bit_cnt_q != 3'd7) begin
            enc_bit   = 1'b1;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else begin
            state_d       = STATE_EOP_SE0;
            enc_force_se0 = 1'b1;
            bit_cnt_d     = '0;
          end
        end
      end

      default: state_d = STATE_IDLE;
    endcase

    // Registered so tx_ready is low while reset is held
    ready_d = !hold_full_d && !is_eop_or_abort(state_d) && !last_acc_d;
  end

  assign tx_ready    = ready_q;
  assign tx_busy     = oe_q;
  assign usb_oe      = oe_q;
  assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_usb_transmitter.sv
// Self-checking bench for usb_transmitter: drives packets over the byte
// stream, records the line every cycle while usb_oe is high and compares it
// with a symbol-level model of SYNC / NRZI / stuffing / abort / EOP.
module tb_usb_transmitter;

  logic       clock48 = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_last = 1'b0;
  logic       tx_ready, tx_busy, tx_underrun;
  logic       usb_d_p_out, usb_d_n_out, usb_oe;

  usb_transmitter #(
    .CLOCKS_PER_BIT(4),
    .EOP_SE0_BITS  (2),
    .STUFF_RUN     (6)
  ) dut (
    .clock48     (clock48),
    .reset_n     (reset_n),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_last     (tx_last),
    .tx_ready    (tx_ready),
    .tx_busy     (tx_busy),
    .tx_underrun (tx_underrun),
    .usb_d_p_out (usb_d_p_out),
    .usb_d_n_out (usb_d_n_out),
    .usb_oe      (usb_oe)
  );

  always #5 clock48 = ~clock48;

  int cyc = 0;
  always @(posedge clock48) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] LJ = 2'b10, LK = 2'b01, LSE0 = 2'b00;

  logic [7:0] pkt[$];
  bit         pkt_last;
  logic [1:0] exp_sym[$];
  int         exp_abort_sym;
  logic [1:0] cap[$];
  int         acc_cyc[$];
  int         first_oe_cyc, ready_cnt, underrun_cnt, underrun_idx, busy_bad;
  bit         feed_to, mon_to;

  function automatic logic [1:0] flip(input logic [1:0] l);
    return (l == LJ) ? LK : LJ;
  endfunction

  // Symbol-level reference: one entry per bit time on the line
  task automatic build_model();
    logic [1:0] lvl;
    logic [7:0] sync;
    int ones;
    exp_sym.delete();
    lvl = LJ;
    sync = 8'h80;
    ones = 0;
    exp_abort_sym = -1;
    for (int i = 0; i < 8; i++) begin
      if (!sync[i]) lvl = flip(lvl);
      exp_sym.push_back(lvl);
    end
    for (int n = 0; n < pkt.size(); n++) begin
      for (int b = 0; b < 8; b++) begin
        if (!pkt[n][b]) begin
          lvl = flip(lvl);
          ones = 0;
        end else begin
          ones++;
        end
        exp_sym.push_back(lvl);
        if (ones == 6) begin
          lvl = flip(lvl);
          exp_sym.push_back(lvl);
          ones = 0;
        end
      end
    end
    if (!pkt_last) begin
      exp_abort_sym = exp_sym.size();
      repeat (8) exp_sym.push_back(lvl);
    end
    exp_sym.push_back(LSE0);
    exp_sym.push_back(LSE0);
    exp_sym.push_back(LJ);
  endtask

  // First cycle where the captured line differs from the model, or -1
  function automatic int line_mismatch();
    int n;
    n = exp_sym.size() * 4;
    for (int i = 0; i < n; i++) begin
      if (i >= cap.size()) return i;
      if (cap[i] !== exp_sym[i / 4]) return i;
    end
    if (cap.size() != n) return n;
    return -1;
  endfunction

  task automatic feed();
    int w;
    for (int i = 0; i < pkt.size(); i++) begin
      tx_valid = 1'b1;
      tx_data  = pkt[i];
      tx_last  = pkt_last && (i == pkt.size() - 1);
      w = 0;
      while (!tx_ready && w < 3000) begin
        @(negedge clock48);
        w++;
      end
      if (w >= 3000) begin
        feed_to = 1'b1;
        break;
      end
      acc_cyc.push_back(cyc + 1);
      @(negedge clock48);
    end
    tx_valid = 1'b0;
    tx_last  = 1'b0;
  endtask

  task automatic monitor();
    int n;
    n = 0;
    while (!usb_oe && n < 3000) begin
      if (tx_ready) ready_cnt++;
      @(negedge clock48);
      n++;
    end
    if (n >= 3000) mon_to = 1'b1;
    first_oe_cyc = cyc;
    n = 0;
    while (usb_oe && n < 5000) begin
      cap.push_back({usb_d_p_out, usb_d_n_out});
      if (tx_busy !== usb_oe) busy_bad++;
      if (tx_ready) ready_cnt++;
      if (tx_underrun) begin
        underrun_cnt++;
        underrun_idx = cap.size() - 1;
      end
      @(negedge clock48);
      n++;
    end
    if (n >= 5000) mon_to = 1'b1;
    if (tx_busy !== 1'b0) busy_bad++;
  endtask

  task automatic run_packet();
    cap.delete();
    acc_cyc.delete();
    ready_cnt = 0;
    underrun_cnt = 0;
    underrun_idx = -1;
    busy_bad = 0;
    feed_to = 1'b0;
    mon_to = 1'b0;
    fork
      feed();
      monitor();
    join
    build_model();
    repeat (3) @(negedge clock48);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock48);
    checks++; if (usb_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b required 0", usb_oe); end
    checks++; if ({usb_d_p_out, usb_d_n_out} !== LJ) begin errors++; $display("FAIL reset_line: got %b required %b", {usb_d_p_out, usb_d_n_out}, LJ); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b required 0", tx_ready); end
    checks++; if ({tx_busy, tx_underrun} !== 2'b00) begin errors++; $display("FAIL reset_busy_underrun: got %b required 00", {tx_busy, tx_underrun}); end
    reset_n = 1'b1;
    repeat (2) @(negedge clock48);
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b required 1", tx_ready); end
  endtask

  task automatic test_single_a5();
    int m;
    pkt = '{8'hA5};
    pkt_last = 1'b1;
    run_packet();
    checks++; if (feed_to || mon_to) begin errors++; $display("FAIL a5_timeout: got feed=%0d mon=%0d required 0 0", feed_to, mon_to); end
    checks++; if (cap.size() != 76) begin errors++; $display("FAIL a5_oe_cycles: got %0d required 76", cap.size()); end
    m = line_mismatch();
    checks++; if (m != -1) begin errors++; $display("FAIL a5_line: got first bad cycle %0d required -1", m); end
    checks++; if (acc_cyc.size() != 1 || first_oe_cyc != acc_cyc[0]) begin errors++; $display("FAIL a5_oe_latency: got oe cycle %0d required accept cycle %0d", first_oe_cyc, (acc_cyc.size() > 0) ? acc_cyc[0] : -1); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL a5_busy_tracks_oe: got %0d bad cycles required 0", busy_bad); end
    checks++; if (ready_cnt != 1) begin errors++; $display("FAIL a5_ready_cycles: got %0d required 1", ready_cnt); end
  endtask

  task automatic test_ff_01();
    int m;
    pkt = '{8'hFF, 8'h01};
    pkt_last = 1'b1;
    run_packet();
    checks++; if (cap.size() != 112) begin errors++; $display("FAIL ff01_oe_cycles: got %0d required 112", cap.size()); end
    m = line_mismatch();
    checks++; if (m != -1) begin errors++; $display("FAIL ff01_line: got first bad cycle %0d required -1", m); end
    checks++; if (underrun_cnt != 0) begin errors++; $display("FAIL ff01_underrun: got %0d required 0", underrun_cnt); end
  endtask

  task automatic test_back_to_back();
    int m;
    pkt = '{8'($urandom), 8'($urandom)};
    pkt_last = 1'b1;
    run_packet();
    checks++; if (acc_cyc.size() != 2 || ready_cnt != 2) begin errors++; $display("FAIL b2b_ready_pulses: got accepts=%0d ready=%0d required 2 2", acc_cyc.size(), ready_cnt); end
    checks++; if (acc_cyc.size() != 2 || acc_cyc[1] - acc_cyc[0] != 33) begin errors++; $display("FAIL b2b_second_accept: got gap %0d required 33", (acc_cyc.size() == 2) ? acc_cyc[1] - acc_cyc[0] : -1); end
    m = line_mismatch();
    checks++; if (m != -1) begin errors++; $display("FAIL b2b_line: got first bad cycle %0d required -1 (bytes %h %h)", m, pkt[0], pkt[1]); end
  endtask

  task automatic test_underrun();
    int m;
    pkt = '{8'hC3};
    pkt_last = 1'b0;
    run_packet();
    checks++; if (underrun_cnt != 1) begin errors++; $display("FAIL underrun_pulses: got %0d required 1", underrun_cnt); end
    checks++; if (underrun_idx != 64) begin errors++; $display("FAIL underrun_position: got %0d required 64", underrun_idx); end
    checks++; if (cap.size() != 108) begin errors++; $display("FAIL underrun_oe_cycles: got %0d required 108", cap.size()); end
    m = line_mismatch();
    checks++; if (m != -1) begin errors++; $display("FAIL underrun_line: got first bad cycle %0d required -1", m); end
  endtask

  task automatic test_reset_mid();
    int m;
    int w;
    tx_valid = 1'b1;
    tx_data  = 8'h5A;
    tx_last  = 1'b0;
    w = 0;
    while (!tx_ready && w < 100) begin @(negedge clock48); w++; end
    @(negedge clock48);
    tx_valid = 1'b0;
    repeat (40) @(negedge clock48);
    checks++; if (usb_oe !== 1'b1) begin errors++; $display("FAIL midreset_active: got oe %b required 1", usb_oe); end
    reset_n = 1'b0;
    #1;
    checks++; if ({usb_oe, usb_d_p_out, usb_d_n_out, tx_ready} !== 4'b0100) begin errors++; $display("FAIL midreset_outputs: got oe,dp,dn,ready=%b required 0100", {usb_oe, usb_d_p_out, usb_d_n_out, tx_ready}); end
    @(negedge clock48);
    reset_n = 1'b1;
    repeat (2) @(negedge clock48);
    pkt = '{8'hD2};
    pkt_last = 1'b1;
    run_packet();
    checks++; if (cap.size() != 76) begin errors++; $display("FAIL midreset_d2_cycles: got %0d required 76", cap.size()); end
    m = line_mismatch();
    checks++; if (m != -1) begin errors++; $display("FAIL midreset_d2_line: got first bad cycle %0d required -1", m); end
  endtask

  task automatic test_stuff_3f();
    int m;
    int se0_at;
    pkt = '{8'h3F};
    pkt_last = 1'b1;
    run_packet();
    se0_at = -1;
    for (int i = 0; i < cap.size(); i++) begin
      if (cap[i] == LSE0) begin se0_at = i; break; end
    end
    checks++; if (se0_at != 68) begin errors++; $display("FAIL 3f_eop_start: got %0d required 68", se0_at); end
    checks++; if (cap.size() != 80) begin errors++; $display("FAIL 3f_oe_cycles: got %0d required 80", cap.size()); end
    m = line_mismatch();
    checks++; if (m != -1) begin errors++; $display("FAIL 3f_line: got first bad cycle %0d required -1", m); end
  endtask

  task automatic test_random();
    int m;
    int len;
    for (int p = 0; p < 6; p++) begin
      len = $urandom_range(1, 4);
      pkt.delete();
      for (int i = 0; i < len; i++)
        pkt.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      pkt_last = 1'b1;
      run_packet();
      m = line_mismatch();
      checks++; if (m != -1) begin errors++; $display("FAIL rand%0d_line: got first bad cycle %0d required -1 (len %0d)", p, m, len); end
      checks++; if (acc_cyc.size() != len || ready_cnt != len) begin errors++; $display("FAIL rand%0d_accepts: got accepts=%0d ready=%0d required %0d", p, acc_cyc.size(), ready_cnt, len); end
      checks++; if (underrun_cnt != 0 || busy_bad != 0) begin errors++; $display("FAIL rand%0d_flags: got underrun=%0d busy_bad=%0d required 0 0", p, underrun_cnt, busy_bad); end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_a5();
    test_ff_01();
    test_back_to_back();
    test_underrun();
    test_reset_mid();
    test_stuff_3f();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
